// File: rtl/uart_tx_pkg.sv
// Shared types for the UART transmit engine: FSM states, line bit-select codes, parity types.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [1:0] {
        START_SEL = 2'd0,
        DATA_SEL  = 2'd1,
        PAR_SEL   = 2'd2,
        STOP_SEL  = 2'd3
    } bit_sel_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic bit_mux(input bit_sel_t sel, input logic ser_bit, input logic par_bit);
        case (sel)
            START_SEL: return 1'b0;
            DATA_SEL:  return ser_bit;
            PAR_SEL:   return par_bit;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Shift register and bit counter for the data phase of a UART frame.
// ser_data is the current LSB; ser_done flags the last data bit on the line.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic                  cnt_clr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  ser_data,
    output logic                  ser_done
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      cnt;

    assign ser_data = shreg[0];
    assign ser_done = (cnt == CNT_W'(DATA_WIDTH - 1));

    // cnt holds the index of the data bit currently on the line; it saturates
    // at the last bit so it can never wrap inside a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= load_data;
            cnt   <= '0;
        end else if (shift_en) begin
            shreg <= {1'b0, shreg[DATA_WIDTH-1:1]};
            if (cnt_clr)
                cnt <= '0;
            else if (!ser_done)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit engine: start bit, DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits.
// Outputs are registered; a new word is accepted only in IDLE or on the last stop cycle.
module uart_tx_frame
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  busy
);

    tx_state_t state;
    logic      par_en_q;
    logic      par_bit_q;
    logic      stop2_q;
    logic      stop_two;
    logic      ser_data;
    logic      ser_done;
    logic      last_stop;
    logic      accept;
    logic      shift_en;
    logic      cnt_clr;

    always_comb begin
        last_stop = (state == STOP) && (!stop2_q || stop_two);
        accept    = Data_valid && ((state == IDLE) || last_stop);
        shift_en  = (state == START) || ((state == DATA) && !ser_done);
        cnt_clr   = (state == START);
    end

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .clk       (CLK),
        .rst       (rst),
        .load      (accept),
        .shift_en  (shift_en),
        .cnt_clr   (cnt_clr),
        .load_data (P_DATA),
        .ser_data  (ser_data),
        .ser_done  (ser_done)
    );

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            TX_OUT    <= 1'b1;
            busy      <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            stop_two  <= 1'b0;
        end else if (accept) begin
            // Frame configuration is frozen here; later input changes are ignored.
            state     <= START;
            TX_OUT    <= bit_mux(START_SEL, ser_data, par_bit_q);
            busy      <= 1'b1;
            par_en_q  <= PAR_EN;
            par_bit_q <= (PAR_TYP == PAR_ODD) ? ~^P_DATA : ^P_DATA;
            stop2_q   <= STOP2;
            stop_two  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                end
                START: begin
                    state  <= DATA;
                    TX_OUT <= bit_mux(DATA_SEL, ser_data, par_bit_q);
                end
                DATA: begin
                    if (!ser_done) begin
                        TX_OUT <= bit_mux(DATA_SEL, ser_data, par_bit_q);
                    end else if (par_en_q) begin
                        state  <= PARITY;
                        TX_OUT <= bit_mux(PAR_SEL, ser_data, par_bit_q);
                    end else begin
                        state    <= STOP;
                        TX_OUT   <= bit_mux(STOP_SEL, ser_data, par_bit_q);
                        stop_two <= 1'b0;
                    end
                end
                PARITY: begin
                    state    <= STOP;
                    TX_OUT   <= bit_mux(STOP_SEL, ser_data, par_bit_q);
                    stop_two <= 1'b0;
                end
                STOP: begin
                    TX_OUT <= bit_mux(STOP_SEL, ser_data, par_bit_q);
                    if (last_stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        stop_two <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmit engine: accepts a parallel word on a valid strobe and shifts out a complete frame on a single serial line. The frame is start bit, data LSB-first, optional even/odd parity, and one or two stop bits. It is the configurable successor of the fixed 8-bit transmit controller. The sequencer, serializer, parity generator and bit mux are integrated in one block. It sits in the UART TX clock domain and is driven by the register file / async FIFO read side.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame; legal range 5..16.
- `CLK` input 1: bit clock; one serial bit per cycle.
- `rst` input 1: asynchronous, active-high reset.
- `P_DATA` input DATA_WIDTH: parallel word; sampled only on an accept edge.
- `Data_valid` input 1: request to send `P_DATA`.
- `PAR_EN` input 1: 1 = parity bit present in the frame.
- `PAR_TYP` input 1: 0 = even, 1 = odd; ignored when `PAR_EN`=0.
- `STOP2` input 1: 0 = one stop bit, 1 = two stop bits.
- `TX_OUT` output 1: serial line, registered; idle level 1.
- `busy` output 1: registered; high while a frame is on the line.

## Operation
- States:
  - IDLE: line 1, busy 0.
  - START: line 0, 1 cycle.
  - DATA: `DATA_WIDTH` cycles, LSB first.
  - PARITY: 1 cycle, only if the latched `PAR_EN`=1.
  - STOP: 1 or 2 cycles per the latched `STOP2`, line 1.
- Transitions:
  - IDLE -> START on `Data_valid`=1.
  - START -> DATA.
  - DATA -> PARITY or STOP when the bit counter reaches `DATA_WIDTH`-1.
  - PARITY -> STOP.
  - STOP, last stop cycle -> START if `Data_valid`=1, else IDLE.
- Accept edge: the rising `CLK` edge that moves the FSM into START.
  - On that edge, latch `P_DATA`, `PAR_EN`, `PAR_TYP` and `STOP2`.
  - Input changes after the accept edge do not affect the frame in flight.
- `Data_valid` is ignored in START, DATA, PARITY and in any stop cycle other than the last. There is no queuing; the source must hold `Data_valid` until it sees an accept.
- Parity:
  - Even: `^data`.
  - Odd: `~^data`.
  - Computed from the latched word.
- Bit counter width is `$clog2(DATA_WIDTH)`. It clears on entry to DATA and never wraps inside a frame.
- Illegal or unreachable state encodings recover to IDLE with `TX_OUT`=1 and `busy`=0.

## Timing
- Reset values: state IDLE, `TX_OUT`=1, `busy`=0, counter 0, shift register 0.
- Reset asserted mid-frame forces these values immediately (asynchronously). The partial frame is dropped and is not resumed after release.
- `TX_OUT` and `busy` both update on the clock edge that enters each state, so the start bit appears on the line in the cycle after the accept edge. There is no combinational path from inputs to outputs.
- Frame length = 1 + `DATA_WIDTH` + `PAR_EN` + (1 + `STOP2`) cycles. Examples: 8N1 = 10 cycles, 8E2 = 12 cycles.
- `busy` rises on the accept edge and stays high through the last stop cycle.
  - It falls on the edge that enters IDLE.
  - On a back-to-back accept it stays high continuously: the start bit of frame N+1 immediately follows the last stop bit of frame N, with zero idle cycles.
- `Data_valid` high in IDLE and in reset release on the same cycle: reset wins. Acceptance occurs on the first edge after deassertion.

## Structure
- Package `uart_tx_pkg` holds:
  - the state enum: IDLE, START, DATA, PARITY, STOP;
  - bit-select codes: START_SEL, DATA_SEL, PAR_SEL, STOP_SEL;
  - parity-type constants: PAR_EVEN = 0, PAR_ODD = 1.
- Sub-module `uart_tx_serializer` (one instance), parametrised by `DATA_WIDTH`:
  - contains the shift register and bit counter;
  - ports: load, shift enable, `ser_data`, `ser_done`.
- The FSM, parity register and output mux/register live in the top level.

## Test plan
- 8N1, `P_DATA`=0xA5, single pulse -> `TX_OUT` over 10 cycles = 0,1,0,1,0,0,1,0,1,1. `busy` high for exactly those 10 cycles, then `TX_OUT`=1 and `busy`=0.
- 8E1 and 8O1, `P_DATA`=0xA5 -> parity bit (cycle 10) is 0 for even and 1 for odd, followed by a stop bit of 1. 0x07 gives even parity 1.
- `DATA_WIDTH`=5, `STOP2`=1, `PAR_EN`=1 even, `P_DATA`=0x1F -> 9-cycle frame 0,1,1,1,1,1,1,1,1.
- `Data_valid` held high across two frames with 0x3C then 0xC3 -> 20 contiguous cycles, no idle bit between the frames. `busy` never drops; the second frame carries 0xC3.
- `P_DATA` and `PAR_EN` changed mid-frame, and `Data_valid` pulsed in DATA and PARITY states -> in-flight frame unchanged; no extra frame is started.
- `rst` asserted in cycle 4 of an 8N1 frame -> `TX_OUT`=1 and `busy`=0 without waiting for a clock edge. After release with `Data_valid`=0, the line stays idle.
